// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencer sitting beside the decode stage. It shadows the register
// write of the instructions currently in EXE and MEM and, from those shadows
// plus the decoded ID fields and the EXE/MEM status lines, drives the stall,
// flush and bubble controls of the PC, IF_ID, ID_EXE and EXE_MEM registers.
//
// Each cycle exactly one condition is taken, in priority order:
//   FREEZE  data memory busy: everything holds, shadows hold
//   FLUSH   EXE redirect: kill IF_ID and ID, shadows advance with a bubble
//   HAZ     RAW / load-use hazard: hold PC and IF_ID, bubble into ID_EXE
//   RUN     ID issues into EXE
//
// Parameters
//   FWD_EN  1: EXE/MEM forwarding present, only load-use in EXE stalls
//           0: no forwarding, any pending write in EXE or MEM stalls
//   CNT_W   width of the saturating HAZ-cycle counter
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   id_valid_i              ID holds a real instruction
//   rs1_addr_i, rs1_re_i    ID source 1 address / read enable
//   rs2_addr_i, rs2_re_i    ID source 2 address / read enable
//   rd_addr_i, rd_we_i      ID destination address / write enable
//   mem_re_i                ID instruction is a load
//   redirect_i              EXE resolved a taken branch/jump this cycle
//   mem_busy_i              data memory not ready for the MEM-stage access
//   pc_stall_o              hold PC
//   if_id_stall_o           hold IF_ID
//   if_id_flush_o           clear IF_ID to NOP
//   id_exe_bubble_o         load NOP into ID_EXE
//   id_exe_stall_o          hold ID_EXE
//   exe_mem_stall_o         hold EXE_MEM
//   state_o                 condition taken last cycle (00 RUN, 01 HAZ,
//                           10 FREEZE, 11 FLUSH), debug only
//   hazard_cnt_o            saturating count of HAZ cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic             rs1_re_i,
    input  logic             rs2_re_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             rd_we_i,
    input  logic             mem_re_i,
    input  logic             redirect_i,
    input  logic             mem_busy_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_exe_bubble_o,
    output logic             id_exe_stall_o,
    output logic             exe_mem_stall_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] hazard_cnt_o
);

    // Register-write summary of one in-flight instruction.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } shadow_t;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StHaz    = 2'b01,
        StFreeze = 2'b10,
        StFlush  = 2'b11
    } state_e;

    shadow_t          ex_q, ex_d;
    shadow_t          mem_q, mem_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_use;
    logic mem_use;
    logic haz;

    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_exe_bubble;
    logic id_exe_stall;
    logic exe_mem_stall;

    // x0 is hardwired, so a write to it never produces a dependency.
    function automatic logic match(input logic [4:0] rs, input logic re, input shadow_t e);
        return re & e.v & e.we & (e.rd != 5'd0) & (e.rd == rs);
    endfunction

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    always_comb begin
        ex_use  = match(rs1_addr_i, rs1_re_i, ex_q) | match(rs2_addr_i, rs2_re_i, ex_q);
        mem_use = match(rs1_addr_i, rs1_re_i, mem_q) | match(rs2_addr_i, rs2_re_i, mem_q);
        if (FWD_EN != 0) begin
            // Forwarding covers everything except a load whose data is not back yet.
            haz = id_valid_i & ex_q.ld & ex_use;
        end else begin
            // Register file is write-first, so WB never needs to stall.
            haz = id_valid_i & (ex_use | mem_use);
        end
    end

    // -------------------------------------------------------------------------
    // Condition select, control outputs and next-state
    // -------------------------------------------------------------------------
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        id_exe_stall  = 1'b0;
        exe_mem_stall = 1'b0;
        ex_d          = ex_q;
        mem_d         = mem_q;
        cnt_d         = cnt_q;
        state_d       = StRun;

        if (mem_busy_i) begin
            // A redirect seen here is ignored: EXE is frozen and will present it again.
            state_d       = StFreeze;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exe_stall  = 1'b1;
            exe_mem_stall = 1'b1;
        end else if (redirect_i) begin
            // Flush wins over a hazard: the hazarding ID instruction is killed anyway.
            state_d       = StFlush;
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
            mem_d         = ex_q;
            ex_d          = '0;
        end else if (haz) begin
            state_d       = StHaz;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exe_bubble = 1'b1;
            mem_d         = ex_q;
            ex_d          = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            state_d  = StRun;
            mem_d    = ex_q;
            ex_d.v   = id_valid_i;
            ex_d.rd  = rd_addr_i;
            ex_d.we  = rd_we_i;
            ex_d.ld  = mem_re_i;
        end
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q    <= '0;
            mem_q   <= '0;
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls are forced low while reset is held, regardless of the status inputs.
    assign pc_stall_o      = pc_stall      & ~rst_i;
    assign if_id_stall_o   = if_id_stall   & ~rst_i;
    assign if_id_flush_o   = if_id_flush   & ~rst_i;
    assign id_exe_bubble_o = id_exe_bubble & ~rst_i;
    assign id_exe_stall_o  = id_exe_stall  & ~rst_i;
    assign exe_mem_stall_o = exe_mem_stall & ~rst_i;
    assign state_o         = state_q;
    assign hazard_cnt_o    = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Two instances share the stimulus: one with forwarding (32-bit counter) and
// one without forwarding (4-bit counter, so saturation is reached). The driver
// computes each cycle's expected response from a pipeline-level model and
// queues it; the monitor pops and compares against the live outputs.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic       rs1_re, rs2_re, rd_we, mem_re;
    logic       redirect, mem_busy;

    logic        f_pc, f_ifs, f_iff, f_bub, f_ids, f_ems;
    logic [1:0]  f_state;
    logic [31:0] f_cnt;
    logic        n_pc, n_ifs, n_iff, n_bub, n_ids, n_ems;
    logic [1:0]  n_state;
    logic [3:0]  n_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) u_dut_fwd (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_re_i(rs1_re), .rs2_re_i(rs2_re),
        .rd_addr_i(rd_addr), .rd_we_i(rd_we), .mem_re_i(mem_re),
        .redirect_i(redirect), .mem_busy_i(mem_busy),
        .pc_stall_o(f_pc), .if_id_stall_o(f_ifs), .if_id_flush_o(f_iff),
        .id_exe_bubble_o(f_bub), .id_exe_stall_o(f_ids), .exe_mem_stall_o(f_ems),
        .state_o(f_state), .hazard_cnt_o(f_cnt)
    );

    hazard_ctrl #(.FWD_EN(0), .CNT_W(4)) u_dut_nofwd (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_re_i(rs1_re), .rs2_re_i(rs2_re),
        .rd_addr_i(rd_addr), .rd_we_i(rd_we), .mem_re_i(mem_re),
        .redirect_i(redirect), .mem_busy_i(mem_busy),
        .pc_stall_o(n_pc), .if_id_stall_o(n_ifs), .if_id_flush_o(n_iff),
        .id_exe_bubble_o(n_bub), .id_exe_stall_o(n_ids), .exe_mem_stall_o(n_ems),
        .state_o(n_state), .hazard_cnt_o(n_cnt)
    );

    // An instruction as it travels down the pipe.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } instr_t;

    // ctl = {pc_stall, if_id_stall, if_id_flush, id_exe_bubble, id_exe_stall, exe_mem_stall}
    typedef struct {
        bit [5:0]        ctl [2];
        bit [1:0]        st  [2];
        longint unsigned cnt [2];
    } exp_t;

    exp_t sb[$];

    // Model state, index 0 = forwarding instance, 1 = no-forwarding instance.
    instr_t          m_exe [2];
    instr_t          m_mem [2];
    int              m_last[2];
    longint unsigned m_cnt [2];
    longint unsigned m_max [2];

    int n_checks = 0;
    int n_errors = 0;

    function automatic bit produces(instr_t p, bit [4:0] r);
        return p.v && p.we && (p.rd != 0) && (p.rd == r);
    endfunction

    function automatic bit needs(instr_t p, bit re1, bit [4:0] r1, bit re2, bit [4:0] r2);
        return (re1 && produces(p, r1)) || (re2 && produces(p, r2));
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // One clock cycle of stimulus: drive, predict, enqueue, advance the model.
    task automatic step(input bit r, input bit v,
                        input bit [4:0] s1, input bit e1, input bit [4:0] s2, input bit e2,
                        input bit [4:0] d, input bit w, input bit l,
                        input bit redir, input bit busy);
        exp_t   e;
        instr_t bub;
        instr_t ni;
        @(negedge clk);
        rst = r; id_valid = v; rs1_addr = s1; rs1_re = e1; rs2_addr = s2; rs2_re = e2;
        rd_addr = d; rd_we = w; mem_re = l; redirect = redir; mem_busy = busy;
        bub = '{v: 0, rd: 0, we: 0, ld: 0};
        ni  = '{v: v, rd: d, we: w, ld: l};
        for (int i = 0; i < 2; i++) begin
            int cond;
            bit hz;
            if (r) begin
                e.ctl[i] = 6'b000000; e.st[i] = 2'd0; e.cnt[i] = 0;
                m_exe[i] = bub; m_mem[i] = bub; m_last[i] = 0; m_cnt[i] = 0;
                continue;
            end
            if (i == 0) hz = v && m_exe[i].ld && needs(m_exe[i], e1, s1, e2, s2);
            else        hz = v && (needs(m_exe[i], e1, s1, e2, s2) || needs(m_mem[i], e1, s1, e2, s2));
            if (busy)       cond = 2;
            else if (redir) cond = 3;
            else if (hz)    cond = 1;
            else            cond = 0;
            case (cond)
                1:       e.ctl[i] = 6'b110100;
                2:       e.ctl[i] = 6'b110011;
                3:       e.ctl[i] = 6'b001100;
                default: e.ctl[i] = 6'b000000;
            endcase
            e.st[i]  = 2'(m_last[i]);
            e.cnt[i] = m_cnt[i];
            m_last[i] = cond;
            if (cond == 1 && m_cnt[i] < m_max[i]) m_cnt[i]++;
            if (cond == 0) begin
                m_mem[i] = m_exe[i]; m_exe[i] = ni;
            end else if (cond != 2) begin
                m_mem[i] = m_exe[i]; m_exe[i] = bub;
            end
        end
        sb.push_back(e);
    endtask

    // Issue a plain instruction (no redirect, no busy).
    task automatic issue(input bit [4:0] s1, input bit e1, input bit [4:0] s2, input bit e2,
                         input bit [4:0] d, input bit w, input bit l);
        step(0, 1, s1, e1, s2, e2, d, w, l, 0, 0);
    endtask

    // Monitor: sampled mid-low-phase, well after the driver and before the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("fwd_ctl", {f_pc, f_ifs, f_iff, f_bub, f_ids, f_ems}, e.ctl[0]);
                check("fwd_state", f_state, e.st[0]);
                check("fwd_cnt", f_cnt, e.cnt[0]);
                check("nofwd_ctl", {n_pc, n_ifs, n_iff, n_bub, n_ids, n_ems}, e.ctl[1]);
                check("nofwd_state", n_state, e.st[1]);
                check("nofwd_cnt", n_cnt, e.cnt[1]);
            end
        end
    end

    initial begin
        int guard;
        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 64'd15;
        rst = 1'b1; id_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_re = 0; rs2_re = 0;
        rd_addr = 0; rd_we = 0; mem_re = 0; redirect = 0; mem_busy = 0;

        // Reset with busy/redirect asserted: controls must still be low.
        step(1, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load x5 then dependent use, repeated; covers load-use and no-forwarding RAW.
        issue(0, 0, 0, 0, 5'd5, 1, 1);
        issue(5'd5, 1, 0, 0, 5'd6, 1, 0);
        issue(5'd5, 1, 0, 0, 5'd6, 1, 0);
        issue(5'd5, 1, 0, 0, 5'd6, 1, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0);

        // ALU write x7, reader via rs2.
        issue(0, 0, 0, 0, 5'd7, 1, 0);
        issue(0, 0, 5'd7, 1, 5'd8, 1, 0);
        issue(0, 0, 5'd7, 1, 5'd8, 1, 0);
        issue(0, 0, 5'd7, 1, 5'd8, 1, 0);

        // Load to x0 never hazards.
        issue(0, 0, 0, 0, 5'd0, 1, 1);
        issue(5'd0, 1, 5'd0, 1, 5'd9, 1, 0);

        // Hazard and redirect in the same cycle.
        issue(0, 0, 0, 0, 5'd4, 1, 1);
        step(0, 1, 5'd4, 1, 0, 0, 5'd1, 1, 0, 1, 0);
        issue(5'd4, 1, 0, 0, 5'd1, 1, 0);

        // Pending load-use held through a three-cycle memory wait.
        issue(0, 0, 0, 0, 5'd3, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 5'd3, 1, 0, 0, 5'd2, 1, 0, k == 1, 1);
        issue(5'd3, 1, 0, 0, 5'd2, 1, 0);
        issue(5'd3, 1, 0, 0, 5'd2, 1, 0);
        issue(0, 0, 0, 0, 0, 0, 0);

        // Back-to-back dependent loads.
        issue(0, 0, 0, 0, 5'd1, 1, 1);
        issue(5'd1, 1, 0, 0, 5'd2, 1, 1);
        issue(5'd1, 1, 0, 0, 5'd2, 1, 1);
        issue(5'd2, 1, 0, 0, 5'd3, 1, 0);
        issue(5'd2, 1, 0, 0, 5'd3, 1, 0);

        // Randomised traffic with occasional mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 249) == 0,
                 $urandom_range(0, 9) != 0,
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) < 12);
        end
        issue(0, 0, 0, 0, 0, 0, 0);

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #4;
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
